// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
package otter_lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SIZE_W = 2;

    localparam logic [XLEN-1:0] MMIO_BASE = 32'h0001_0000;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE  = 2'd0;
    localparam lsu_state_t ST_ISSUE = 2'd1;
    localparam lsu_state_t ST_WAIT  = 2'd2;
    localparam lsu_state_t ST_RESP  = 2'd3;

    // Request as latched at acceptance; drives the memory port until IDLE.
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [SIZE_W-1:0] size;
        logic              sign;
    } lsu_req_t;

endpackage

// File: rtl/otter_lsu_align.sv
// Access-size vs byte-offset legality check (halfwords may not cross a word).
module otter_lsu_align
    import otter_lsu_pkg::*;
(
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        offset,
    output logic              legal_c
);

    always_comb begin
        legal_c = 1'b0;
        case (size)
            SIZE_BYTE: legal_c = 1'b1;
            SIZE_HALF: legal_c = (offset != 2'd3);
            SIZE_WORD: legal_c = (offset == 2'd0);
            default:   legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/otter_lsu.sv
// Load/store initiator: one request at a time into OTTER memory port 2,
// with misalignment trapping and a buffered valid/ready response.
module otter_lsu
    import otter_lsu_pkg::*;
#(
    parameter logic [XLEN-1:0] MMIO_ADDR_BASE = MMIO_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_io,
    output logic              mem_rden2,
    output logic              mem_we2,
    output logic [XLEN-1:0]   mem_addr2,
    output logic [XLEN-1:0]   mem_din2,
    output logic [SIZE_W-1:0] mem_size,
    output logic              mem_sign,
    input  logic [XLEN-1:0]   mem_dout2
);

    lsu_state_t      state, state_nxt;
    lsu_req_t        req_q, req_nxt;
    logic [XLEN-1:0] rdata_nxt;
    logic            err_nxt;
    logic            io_nxt;
    logic            rden_nxt;
    logic            we_nxt;
    logic            legal_c;

    otter_lsu_align u_align (
        .size    (req_size),
        .offset  (req_addr[1:0]),
        .legal_c (legal_c)
    );

    // Memory port always reflects the latched request.
    assign mem_addr2 = req_q.addr;
    assign mem_din2  = req_q.wdata;
    assign mem_size  = req_q.size;
    assign mem_sign  = req_q.sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_io    <= 1'b0;
            mem_rden2 <= 1'b0;
            mem_we2   <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            rsp_valid <= (state_nxt == ST_RESP);
            rsp_rdata <= rdata_nxt;
            rsp_err   <= err_nxt;
            rsp_io    <= io_nxt;
            mem_rden2 <= rden_nxt;
            mem_we2   <= we_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        rdata_nxt = rsp_rdata;
        err_nxt   = rsp_err;
        io_nxt    = rsp_io;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    req_nxt.we    = req_we;
                    req_nxt.addr  = req_addr;
                    req_nxt.wdata = req_wdata;
                    req_nxt.size  = req_size;
                    req_nxt.sign  = req_sign;
                    io_nxt        = (req_addr >= MMIO_ADDR_BASE);
                    rdata_nxt     = '0;
                    err_nxt       = !legal_c;
                    state_nxt     = legal_c ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_nxt = req_q.we ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                rdata_nxt = mem_dout2;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        rden_nxt = (state_nxt == ST_ISSUE) && !req_nxt.we;
        we_nxt   = (state_nxt == ST_ISSUE) && req_nxt.we;
    end

endmodule

// File: doc/otter_lsu.md
# otter_lsu

Load/store initiator sitting between the OTTER core's execute stage and data port 2 of the OTTER memory. Accepts one load or store request at a time over a valid/ready handshake and sequences the memory's synchronous-read port (RDEN2/WE2/ADDR2/DIN2/SIZE/SIGN → DOUT2). Holds address and size stable across the read-latency cycle, traps misaligned accesses before they reach memory, and returns a buffered response over a second valid/ready handshake.

## Interface
- MMIO_BASE, 32'h0001_0000, first byte address decoded as memory-mapped IO by the memory.
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  core presents a request.
- REQ_READY  out  1  LSU can accept; high only in IDLE.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data, right-justified.
- REQ_SIZE  in  2  0 byte, 1 half, 2 word.
- REQ_SIGN  in  1  1 unsigned, 0 signed (loads).
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  core consumes response.
- RSP_RDATA  out  32  sized/extended load data; 0 for stores and errors.
- RSP_ERR  out  1  misaligned/unsupported access, memory not touched.
- RSP_IO  out  1  address was ≥ MMIO_BASE.
- MEM_RDEN2, MEM_WE2  out  1 each  memory read / write enable.
- MEM_ADDR2, MEM_DIN2  out  32 each  memory address / store data.
- MEM_SIZE  out  2;  MEM_SIGN  out  1  to memory.
- MEM_DOUT2  in  32  memory read data, valid the cycle after RDEN2.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY latch WE, ADDR, WDATA, SIZE, SIGN; go ISSUE, or RESP with ERR=1 if misaligned.
- Alignment legal set: size 0 any offset; size 1 offset 0,1,2; size 2 offset 0. Size 3 or any other combo → ERR.
- ISSUE (one cycle): MEM_RDEN2=!WE or MEM_WE2=WE. Store → RESP. Load → WAIT.
- WAIT: enables low, MEM_ADDR2/SIZE/SIGN still driven from latched request (memory sizes DOUT2 combinationally from them); capture MEM_DOUT2 into RSP_RDATA register at end of cycle; go RESP.
- RESP: RSP_VALID=1, RSP_RDATA/ERR/IO held stable until RSP_READY; then IDLE.
- MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN are always the latched request registers (stable ISSUE→RESP). MEM_RDEN2/MEM_WE2 decoded from state only; never high outside ISSUE, never both high.
- RSP_IO = latched ADDR ≥ MMIO_BASE (unsigned compare), reported for errors too.
- New request not accepted in same cycle RSP handshake completes.

## Timing
- Reset (async assert, any state): state IDLE, all latched regs 0, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, RSP_IO=0, MEM_RDEN2=0, MEM_WE2=0, MEM_ADDR2/DIN2=0, MEM_SIZE=0, MEM_SIGN=0. Mid-ISSUE reset drops WE2 immediately; the write is aborted or complete per memory edge, not retried.
- Accept at edge N: load RSP_VALID from N+3, store from N+2, error from N+1 (RSP_READY held high).
- Back-to-back: next accept at earliest the edge after RSP handshake; load throughput one per 4 cycles.
- RSP_READY held low: RESP persists indefinitely, memory idle.
- REQ inputs ignored outside IDLE.

## Structure
- Package otter_lsu_pkg: state enum, size constants SIZE_BYTE/HALF/WORD, default MMIO_BASE.
- One combinational sub-module natural: otter_lsu_align (size, addr[1:0] → legal), reused by future decode-time checks.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load signed word 0x100 → WE2 one cycle with ADDR2=0x100; load RSP_RDATA=0xDEADBEEF at N+3, ERR=0, IO=0.
- Load signed byte from 0x103 holding 0x80xxxxxx → RSP_RDATA=0xFFFFFF80; unsigned → 0x00000080; ADDR2/SIZE stable through WAIT.
- Load word at 0x102 and half at 0x103 → RSP_ERR=1, RSP_RDATA=0, response at N+1, RDEN2/WE2 never asserted.
- Load word from 0x11000000 with IO_IN=0x12345678 → RSP_IO=1, RSP_RDATA=0x12345678.
- Hold RSP_READY low 5 cycles on a load → RSP_VALID and data stable, REQ_READY=0, no memory enables.
- Assert RST_N low during ISSUE of a store → WE2 drops same cycle, outputs at reset values, REQ_READY=1 after release.
